// File: rtl/nibble_serializer.sv
// Serializes a 4-bit nibble LSB-first onto d_out, pulsing en_out at the end of each bit window.
// Optional `PARITY_EN appends an even-parity bit window with its own par_en strobe.
module nibble_serializer #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] load_data,
  input  logic       load_valid,
  output logic       load_ready,
  output logic       d_out,
  output logic       en_out,
  output logic       busy,
  output logic       done
`ifdef PARITY_EN
  ,
  output logic       par_en
`endif
);

  localparam int unsigned CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic SINGLE        = (CLKS_PER_BIT == 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t          r_state;
  logic [3:0]      r_data;
  logic [1:0]      r_bit;
  logic [CW-1:0]   r_cnt;

  logic            w_cnt_last;
  logic            w_next_last;
  logic [CW-1:0]   w_cnt_inc;
  logic [1:0]      w_bit_inc;

  assign w_cnt_last  = (r_cnt == LAST);
  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_next_last = (w_cnt_inc == LAST);
  assign w_bit_inc   = r_bit + 2'd1;

  // Outputs are computed for the upcoming cycle so every port comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_data     <= 4'd0;
      r_bit      <= 2'd0;
      r_cnt      <= '0;
      load_ready <= 1'b1;
      d_out      <= 1'b0;
      en_out     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef PARITY_EN
      par_en     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_valid) begin
            r_state    <= SHIFT;
            r_data     <= load_data;
            r_bit      <= 2'd0;
            r_cnt      <= '0;
            load_ready <= 1'b0;
            busy       <= 1'b1;
            d_out      <= load_data[0];
            en_out     <= SINGLE;
          end else begin
            load_ready <= 1'b1;
            busy       <= 1'b0;
            d_out      <= 1'b0;
            en_out     <= 1'b0;
          end
        end
        SHIFT: begin
          if (!w_cnt_last) begin
            r_cnt  <= w_cnt_inc;
            en_out <= w_next_last;
          end else if (r_bit != 2'd3) begin
            r_bit  <= w_bit_inc;
            r_cnt  <= '0;
            d_out  <= r_data[w_bit_inc];
            en_out <= SINGLE;
          end else begin
            r_cnt  <= '0;
            r_bit  <= 2'd0;
            en_out <= 1'b0;
`ifdef PARITY_EN
            r_state <= PARITY;
            d_out   <= ^r_data;
            par_en  <= SINGLE;
`else
            r_state    <= IDLE;
            d_out      <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
            done       <= 1'b1;
`endif
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          if (!w_cnt_last) begin
            r_cnt  <= w_cnt_inc;
            par_en <= w_next_last;
          end else begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            par_en     <= 1'b0;
            d_out      <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
            done       <= 1'b1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer: CLKS_PER_BIT=1 and =3 instances, with a model of the
// downstream shift register fed by d_out/en_out.
module tb_nibble_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d1 = 4'd0, d3 = 4'd0;
  logic       v1 = 1'b0, v3 = 1'b0;
  logic       rdy1, do1, en1, bsy1, dn1;
  logic       rdy3, do3, en3, bsy3, dn3;
`ifdef PARITY_EN
  logic       pe1, pe3;
`endif
  logic [3:0] sr1 = 4'd0, sr3 = 4'd0;
  logic [4:0] vec1, vec3;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  nibble_serializer #(.CLKS_PER_BIT(1)) u1 (
    .clk(clk), .rst(rst), .load_data(d1), .load_valid(v1), .load_ready(rdy1),
    .d_out(do1), .en_out(en1), .busy(bsy1), .done(dn1)
`ifdef PARITY_EN
    , .par_en(pe1)
`endif
  );

  nibble_serializer #(.CLKS_PER_BIT(3)) u3 (
    .clk(clk), .rst(rst), .load_data(d3), .load_valid(v3), .load_ready(rdy3),
    .d_out(do3), .en_out(en3), .busy(bsy3), .done(dn3)
`ifdef PARITY_EN
    , .par_en(pe3)
`endif
  );

  assign vec1 = {rdy1, bsy1, en1, dn1, do1};
  assign vec3 = {rdy3, bsy3, en3, dn3, do3};

  // Downstream register {D,C,B,A}: d_in enters D, A ends up holding the first bit sent.
  always @(posedge clk) begin
    if (en1) sr1 <= {do1, sr1[3:1]};
    if (en3) sr3 <= {do3, sr3[3:1]};
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // vec = {load_ready, busy, en_out, done, d_out}
  initial begin
    logic [3:0] nib;
    logic [4:0] ex;
    repeat (2) tick();
    chk("reset_outputs", {4'd0, vec1[3:0]}, 8'h00);
    chk("reset_outputs3", {4'd0, vec3[3:0]}, 8'h00);

`ifdef PARITY_EN
    rst = 1'b0;
    v1 = 1'b1; d1 = 4'b0111;
    tick(); v1 = 1'b0; d1 = 4'h0;
    nib = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("par_data_%0d", k), {2'd0, pe1, vec1}, {3'b000, 4'b0110, nib[k]});
      tick();
    end
    chk("par_bit", {2'd0, pe1, vec1}, {3'b001, 5'b01001});
    tick();
    chk("par_done", {2'd0, pe1, vec1}, {3'b000, 5'b10010});
    chk("par_sr", {4'd0, sr1}, 8'h07);
    tick();
    chk("par_idle", {2'd0, pe1, vec1}, {3'b000, 5'b10000});
`else
    // First accept on the first edge after reset release.
    rst = 1'b0;
    v1 = 1'b1; d1 = 4'b1011;
    tick(); v1 = 1'b0; d1 = 4'h0;
    nib = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b1011_bit%0d", k), {3'd0, vec1}, {3'd0, 4'b0110, nib[k]});
      tick();
    end
    chk("b1011_done", {3'd0, vec1}, {3'd0, 5'b10010});
    chk("b1011_sr", {4'd0, sr1}, 8'h0B);
    tick();
    chk("b1011_idle", {3'd0, vec1}, {3'd0, 5'b10000});

    // Idle with no valid.
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("idle_%0d", k), {3'd0, vec1}, {3'd0, 5'b10000});
    end

    // Back-to-back: A accepted, data switched to 5 during SHIFT, 5 accepted in the done cycle.
    v1 = 1'b1; d1 = 4'hA;
    tick(); d1 = 4'h5;
    nib = 4'hA;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bb_A_bit%0d", k), {3'd0, vec1}, {3'd0, 4'b0110, nib[k]});
      tick();
    end
    chk("bb_A_done", {3'd0, vec1}, {3'd0, 5'b10010});
    chk("bb_A_sr", {4'd0, sr1}, 8'h0A);
    tick(); v1 = 1'b0; d1 = 4'hF;
    nib = 4'h5;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bb_5_bit%0d", k), {3'd0, vec1}, {3'd0, 4'b0110, nib[k]});
      tick();
    end
    chk("bb_5_done", {3'd0, vec1}, {3'd0, 5'b10010});
    chk("bb_5_sr", {4'd0, sr1}, 8'h05);
    tick();
    chk("bb_idle", {3'd0, vec1}, {3'd0, 5'b10000});

    // Reset abort after two strobes of F.
    v1 = 1'b1; d1 = 4'hF;
    tick(); v1 = 1'b0;
    chk("abort_s1", {3'd0, vec1}, {3'd0, 5'b01101});
    tick();
    chk("abort_s2", {3'd0, vec1}, {3'd0, 5'b01101});
    #2 rst = 1'b1;
    #1 chk("abort_now", {4'd0, vec1[3:0]}, 8'h00);
    tick(); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("abort_nodone_%0d", k), {3'd0, vec1}, {3'd0, 5'b10000});
    end
    v1 = 1'b1; d1 = 4'h3;
    tick(); v1 = 1'b0;
    nib = 4'h3;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("post_3_bit%0d", k), {3'd0, vec1}, {3'd0, 4'b0110, nib[k]});
      tick();
    end
    chk("post_3_done", {3'd0, vec1}, {3'd0, 5'b10010});
    chk("post_3_sr", {4'd0, sr1}, 8'h03);

    // CLKS_PER_BIT=3: strobes on cycles 3,6,9,12, done on 13.
    v3 = 1'b1; d3 = 4'b0110;
    tick(); v3 = 1'b0; d3 = 4'h9;
    nib = 4'b0110;
    for (int k = 1; k <= 14; k++) begin
      if (k <= 12)      ex = {2'b01, (k % 3 == 0), 1'b0, nib[(k - 1) / 3]};
      else if (k == 13) ex = 5'b10010;
      else              ex = 5'b10000;
      chk($sformatf("c3_cyc%0d", k), {3'd0, vec3}, {3'd0, ex});
      if (k == 13) chk("c3_sr", {4'd0, sr3}, 8'h06);
      tick();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nibble_serializer.md
NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1: clock cycles each serial bit is held on d_out; legal range 1..255.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 load_data  input  4  nibble to serialize, sampled on accept.
REQ-005 load_valid  input  1  upstream offers load_data.
REQ-006 load_ready  output  1  block can accept a nibble this cycle.
REQ-007 d_out  output  1  serial data; drives the downstream shift register's d_in.
REQ-008 en_out  output  1  shift strobe; drives the downstream shift register's en.
REQ-009 busy  output  1  high while a nibble is being transmitted.
REQ-010 done  output  1  one-cycle pulse when a nibble transmission completes.

Function
REQ-011 The block shall use states IDLE and SHIFT, plus PARITY when PARITY_EN is defined.
REQ-012 In IDLE: load_ready=1, busy=0, d_out=0, en_out=0.
REQ-013 An accept shall occur on a rising edge where load_valid=1 and load_ready=1: capture load_data, clear bit index and cycle counter, go to SHIFT.
REQ-014 In SHIFT: load_ready=0, busy=1; load_valid shall be ignored and load_data shall not affect the captured nibble.
REQ-015 Bit order: LSB first. Bit k (k=0..3) of the captured nibble is driven on d_out for exactly CLKS_PER_BIT consecutive cycles.
REQ-016 en_out shall be 1 only in the final cycle of each data-bit window: exactly 4 en_out cycles per nibble. With CLKS_PER_BIT=1, en_out is high for 4 consecutive cycles.
REQ-017 Downstream result: after the 4th en_out, the downstream register holds A=data[0], B=data[1], C=data[2], D=data[3].
REQ-018 First SHIFT cycle is the cycle after the accept edge. Nibble occupancy is 4*CLKS_PER_BIT cycles in SHIFT, plus PARITY cycles if enabled.
REQ-019 After the last window, the block shall return to IDLE, with done=1 in that first IDLE cycle only.
REQ-020 Back-to-back: an accept in the done cycle is legal. Sustained throughput is one nibble per 4*CLKS_PER_BIT+1 cycles (no PARITY).
REQ-021 The cycle counter shall be wide enough for CLKS_PER_BIT-1. The bit index shall be 2 bits and shall not wrap into a 5th data bit.
REQ-022 All outputs shall be registered, or decoded from registered state only; no combinational path from load_valid or load_data to any output.

Reset
REQ-023 While rst=1: state=IDLE, captured nibble=0, counters=0, d_out=0, en_out=0, busy=0, done=0; load_ready=1 once rst deasserts.
REQ-024 rst asserted mid-transmission shall abort immediately: no further en_out, no done pulse for the aborted nibble.
REQ-025 The first accept after rst deassertion shall be possible on the first rising edge with load_valid=1.

Configuration
REQ-026 Macro PARITY_EN. When defined, a PARITY state of CLKS_PER_BIT cycles shall follow SHIFT.
REQ-027 In PARITY, d_out shall be the even parity of the nibble, i.e. the XOR of data[3:0].
REQ-028 In PARITY, en_out=0 and busy=1. An extra 1-bit output par_en shall be high in the final PARITY cycle only; done follows PARITY.
REQ-029 When PARITY_EN is not defined: no PARITY state, no par_en port, and timing is exactly as in REQ-018 to REQ-020.

Verification
REQ-030 CLKS_PER_BIT=1, accept 4'b1011 -> d_out=1,1,0,1 on the 4 cycles after accept; en_out high for those 4 cycles; done next cycle; model register reads D,C,B,A=1,0,1,1.
REQ-031 CLKS_PER_BIT=3, accept 4'b0110 -> each bit held 3 cycles; en_out high on cycles 3,6,9,12 after accept; done on cycle 13.
REQ-032 load_valid held high with 4'hA then 4'h5 -> second accept in the done cycle; 5-cycle spacing between accepts; load_data changes during SHIFT ignored.
REQ-033 rst pulsed after 2 en_out strobes of 4'hF -> all outputs 0 immediately; no done; next accept of 4'h3 transmits correctly.
REQ-034 PARITY_EN, CLKS_PER_BIT=1, accept 4'b0111 -> 4 data strobes, then d_out=1 with en_out=0 and par_en=1, then done.
REQ-035 Idle with load_valid=0 for 20 cycles -> en_out, busy and done stay 0; load_ready stays 1.
